// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: types and constants shared by the memory-port arbiter.
//   arb_state_t : arbiter ownership state; its numeric value is the debug
//                 code seen on mem_arbiter.state_dbg (CPU_OWN=0, DMA_OWN=1,
//                 RELEASE=2).
//   MEM_READ    : rW level that makes testmemory perform a read, which is the
//                 safe idle level for the port.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    DMA_OWN = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic MEM_READ = 1'b1;

endpackage

// File: rtl/mem_arbiter_burst_counter.sv
// mem_arbiter_burst_counter: counts DMA accesses accepted during one grant.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset, clears the count
//   clr_i   : clear the count (takes priority over inc_i)
//   inc_i   : one access accepted this cycle
//   limit_o : the access accepted this cycle is the MAX_BURST-th one
// The count saturates at MAX_BURST and never wraps.
module mem_arbiter_burst_counter #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q < CNT_W'(MAX_BURST))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flags the access that brings the count up to the limit, so the arbiter
  // can let that access finish and release on the same edge.
  assign limit_o = inc_i && (count_q == CNT_W'(MAX_BURST - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the test-memory port between the CPU datapath and a
// DMA / program-loader master.
//   clk, rst_n          : clock, synchronous active-low reset
//   cpu_addr/wdata/rw   : CPU side of the memory bus
//   cpu_sync            : CPU opcode-fetch cycle (instruction boundary)
//   cpu_stall           : freezes the CPU control FSM while DMA holds the bus
//   dma_req             : DMA asks for ownership (level)
//   dma_valid/addr/wdata/rw : DMA access, only honoured while granted
//   dma_ready           : DMA access accepted this cycle (zero wait)
//   dma_rdata/dma_rvalid: read data, one cycle after an accepted read
//   grant_dma           : DMA owns the port
//   mem_addr/wdata/rw   : to testmemory; mem_rdata from testmemory
//   state_dbg           : arbiter state code (0 CPU, 1 DMA, 2 release)
// DMA is granted only on a CPU fetch cycle; a grant is limited to MAX_BURST
// accepted accesses, after which the CPU gets at least one instruction in.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  input  logic        cpu_sync,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_valid,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_rw,
  output logic        dma_ready,
  output logic [7:0]  dma_rdata,
  output logic        dma_rvalid,
  output logic        grant_dma,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rw,
  input  logic [7:0]  mem_rdata,
  output logic [1:0]  state_dbg
);

  arb_state_t state_q, state_d;
  logic       fair_q, fair_d;
  logic       rvalid_q;
  logic       accept;
  logic       limit_hit;

  // While reset is asserted nothing is accepted, so a DMA write that
  // coincides with reset never reaches the memory.
  assign accept = rst_n && (state_q == DMA_OWN) && dma_valid;

  mem_arbiter_burst_counter #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_burst_counter (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (state_q == RELEASE),
    .inc_i   (accept),
    .limit_o (limit_hit)
  );

  always_comb begin
    state_d = state_q;
    fair_d  = fair_q;
    unique case (state_q)
      CPU_OWN: begin
        if (cpu_sync) begin
          if (dma_req && !fair_q) begin
            state_d = DMA_OWN;
          end else begin
            // A boundary passed without a grant: the CPU got its instruction.
            fair_d = 1'b0;
          end
        end
      end
      DMA_OWN: begin
        if (limit_hit) begin
          state_d = RELEASE;
          fair_d  = 1'b1;
        end else if (!dma_req) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = CPU_OWN;
      default: state_d = CPU_OWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CPU_OWN;
      fair_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fair_q   <= fair_d;
      rvalid_q <= accept && dma_rw;
    end
  end

  assign grant_dma = (state_q == DMA_OWN);
  assign cpu_stall = (state_q != CPU_OWN);
  assign dma_ready = accept;
  assign state_dbg = state_q;

  assign mem_addr  = grant_dma ? dma_addr  : cpu_addr;
  assign mem_wdata = grant_dma ? dma_wdata : cpu_wdata;

  always_comb begin
    mem_rw = cpu_rw;
    if (!rst_n) begin
      mem_rw = MEM_READ;
    end else if (grant_dma) begin
      mem_rw = dma_valid ? dma_rw : MEM_READ;
    end
  end

  // testmemory registers its read data, so in the cycle after an accepted
  // read mem_rdata already holds the word; it is passed through only while
  // dma_rvalid is high and reads as zero otherwise.
  assign dma_rvalid = rvalid_q;
  assign dma_rdata  = rvalid_q ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic        cpu_sync;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_valid;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_rw;
  logic        dma_ready;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic        grant_dma;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rw;
  logic [7:0]  mem_rdata;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rw(cpu_rw),
    .cpu_sync(cpu_sync), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_valid(dma_valid), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rw(dma_rw), .dma_ready(dma_ready),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .grant_dma(grant_dma),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // Clocked-read test memory model
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_rw == 1'b0) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: expected read data pushed on an accepted read, popped when
  // the read data is due one cycle later.
  logic [7:0] sb[$];
  logic [7:0] shadow [logic [15:0]];
  logic       mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0) begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("sb_rvalid", dma_rvalid, 1'b1);
        chk("sb_rdata", dma_rdata, e);
      end else begin
        chk("sb_no_rvalid", dma_rvalid, 1'b0);
      end
      if (dma_ready && dma_rw)
        sb.push_back(shadow.exists(dma_addr) ? shadow[dma_addr] : 8'h00);
      if (dma_ready && !dma_rw)
        shadow[dma_addr] = dma_wdata;
    end
  end

  typedef struct {
    logic        sync, req, valid;
    logic [15:0] daddr;
    logic [7:0]  dwd;
    logic        drw;
    logic [15:0] caddr;
    logic [7:0]  cwd;
    logic        crw;
    logic        g, s, rw;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        rdy;
    logic [1:0]  st;
  } vec_t;

  function automatic vec_t mk(
    input logic sync, input logic req, input logic valid,
    input logic [15:0] daddr, input logic [7:0] dwd, input logic drw,
    input logic [15:0] caddr, input logic [7:0] cwd, input logic crw,
    input logic g, input logic s, input logic rw,
    input logic [15:0] addr, input logic [7:0] wd, input logic rdy,
    input logic [1:0] st);
    vec_t v;
    v.sync = sync; v.req = req; v.valid = valid;
    v.daddr = daddr; v.dwd = dwd; v.drw = drw;
    v.caddr = caddr; v.cwd = cwd; v.crw = crw;
    v.g = g; v.s = s; v.rw = rw; v.addr = addr; v.wd = wd;
    v.rdy = rdy; v.st = st;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sync, input logic req, input logic valid,
                       input logic [15:0] daddr, input logic [7:0] dwd,
                       input logic drw);
    cpu_sync  = sync;
    dma_req   = req;
    dma_valid = valid;
    dma_addr  = daddr;
    dma_wdata = dwd;
    dma_rw    = drw;
  endtask

  vec_t vecs [14];
  int   pulses;

  initial begin
    // idle/reset, late strobe, boundary wait, write/read, release,
    // CPU pass-through, req dropping with a valid access
    vecs[0]  = mk(0,0,0, 16'h0000,8'h00,1, 16'h0200,8'h11,1, 0,0,1, 16'h0200,8'h11,0, 2'd0);
    vecs[1]  = mk(0,1,1, 16'h0300,8'hA5,0, 16'h0200,8'h11,1, 0,0,1, 16'h0200,8'h11,0, 2'd0);
    vecs[2]  = mk(0,1,0, 16'h0300,8'hA5,0, 16'h0200,8'h11,1, 0,0,1, 16'h0200,8'h11,0, 2'd0);
    vecs[3]  = mk(0,1,0, 16'h0300,8'hA5,0, 16'h0200,8'h11,1, 0,0,1, 16'h0200,8'h11,0, 2'd0);
    vecs[4]  = mk(1,1,0, 16'h0300,8'hA5,0, 16'h0200,8'h11,1, 0,0,1, 16'h0200,8'h11,0, 2'd0);
    vecs[5]  = mk(1,1,1, 16'h0300,8'hA5,0, 16'h0200,8'h11,1, 1,1,0, 16'h0300,8'hA5,1, 2'd1);
    vecs[6]  = mk(1,1,1, 16'h0300,8'hA5,1, 16'h0200,8'h11,1, 1,1,1, 16'h0300,8'hA5,1, 2'd1);
    vecs[7]  = mk(1,0,0, 16'h0300,8'hA5,1, 16'h0200,8'h11,1, 1,1,1, 16'h0300,8'hA5,0, 2'd1);
    vecs[8]  = mk(1,0,1, 16'h0300,8'hA5,0, 16'h0200,8'h11,1, 0,1,1, 16'h0200,8'h11,0, 2'd2);
    vecs[9]  = mk(0,0,0, 16'h0300,8'hA5,0, 16'h0204,8'h77,0, 0,0,0, 16'h0204,8'h77,0, 2'd0);
    vecs[10] = mk(1,1,0, 16'h0301,8'h3C,0, 16'h0200,8'h11,1, 0,0,1, 16'h0200,8'h11,0, 2'd0);
    vecs[11] = mk(1,0,1, 16'h0301,8'h3C,0, 16'h0200,8'h11,1, 1,1,0, 16'h0301,8'h3C,1, 2'd1);
    vecs[12] = mk(1,0,0, 16'h0301,8'h3C,0, 16'h0200,8'h11,1, 0,1,1, 16'h0200,8'h11,0, 2'd2);
    vecs[13] = mk(0,0,0, 16'h0301,8'h3C,0, 16'h0200,8'h11,1, 0,0,1, 16'h0200,8'h11,0, 2'd0);

    rst_n = 1'b0;
    cpu_addr = 16'h0200; cpu_wdata = 8'h11; cpu_rw = 1'b1;
    drive(0, 0, 0, 16'h0000, 8'h00, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].sync, vecs[i].req, vecs[i].valid, vecs[i].daddr, vecs[i].dwd, vecs[i].drw);
      cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd; cpu_rw = vecs[i].crw;
      @(negedge clk);
      chk($sformatf("row%0d_grant", i), grant_dma, vecs[i].g);
      chk($sformatf("row%0d_stall", i), cpu_stall, vecs[i].s);
      chk($sformatf("row%0d_mem_rw", i), mem_rw, vecs[i].rw);
      chk($sformatf("row%0d_mem_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("row%0d_mem_wdata", i), mem_wdata, vecs[i].wd);
      chk($sformatf("row%0d_ready", i), dma_ready, vecs[i].rdy);
      chk($sformatf("row%0d_state", i), state_dbg, vecs[i].st);
      tick();
    end

    // Burst limit: 4 accepted reads, one RELEASE cycle, then CPU_OWN
    drive(1, 1, 0, 16'h0300, 8'h00, 1'b1);
    tick();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, (i % 2 == 1) ? 16'h0301 : 16'h0300, 8'h00, 1'b1);
      @(negedge clk);
      pulses += int'(dma_ready);
      chk($sformatf("burst%0d_state", i), state_dbg,
          (i < 4) ? 2'd1 : ((i == 4) ? 2'd2 : 2'd0));
      if (i == 4) chk("burst_release_rvalid", dma_rvalid, 1'b1);
      tick();
    end
    chk("burst_ready_pulses", pulses, 4);

    // Fairness: first boundary after a forced release is not granted
    drive(1, 1, 0, 16'h0300, 8'h00, 1'b1);
    tick();
    drive(0, 1, 0, 16'h0300, 8'h00, 1'b1);
    @(negedge clk);
    chk("fair_no_grant", grant_dma, 1'b0);
    chk("fair_no_stall", cpu_stall, 1'b0);
    tick();
    drive(1, 1, 0, 16'h0300, 8'h00, 1'b1);
    tick();
    drive(0, 1, 0, 16'h0300, 8'h00, 1'b1);
    @(negedge clk);
    chk("fair_second_grant", grant_dma, 1'b1);
    tick();

    // Reset in the middle of a burst, during the second DMA write
    drive(0, 1, 1, 16'h0310, 8'h5A, 1'b0);
    tick();
    drive(0, 1, 1, 16'h0311, 8'h6B, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 16'h0311, 8'h6B, 1'b1);
    @(negedge clk);
    chk("rst_mid_grant", grant_dma, 1'b0);
    chk("rst_mid_stall", cpu_stall, 1'b0);
    chk("rst_mid_mem_rw", mem_rw, 1'b1);
    chk("rst_mid_rvalid", dma_rvalid, 1'b0);
    chk("rst_mid_state", state_dbg, 2'd0);
    tick();

    // Counter restarted from zero: a full burst of 4 writes is accepted
    drive(1, 1, 0, 16'h0320, 8'h00, 1'b0);
    tick();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 16'(16'h0320 + i), 8'(i), 1'b0);
      @(negedge clk);
      pulses += int'(dma_ready);
      tick();
    end
    chk("rst_count_pulses", pulses, 4);

    drive(0, 0, 0, 16'h0000, 8'h00, 1'b1);
    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
